// File: rtl/dmem_arbiter.sv
// Data-memory sequencer: arbitrates the pipeline MEM stage and a word-wide secondary port
// onto a single dmem port, with byte-lane formatting, load extension and stall generation.
module dmem_arbiter #(
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_req,
    input  logic        p_we,
    input  logic [1:0]  p_size,
    input  logic        p_unsigned,
    input  logic [31:0] p_addr,
    input  logic [31:0] p_wdata,
    output logic [31:0] p_rdata,
    output logic        p_done,
    output logic        p_stall,
    output logic        misalign,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        m_en,
    output logic        m_we,
    output logic [3:0]  m_be,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    localparam int unsigned CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
    localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        MISAL,
        ACCESS,
        DONE
    } state_t;

    state_t        state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [SW-1:0] starve_q, starve_n;
    logic          own_d_q, own_d_n;
    logic          we_q, we_n;
    logic [1:0]    size_q, size_n;
    logic          uns_q, uns_n;
    logic [1:0]    lane_q, lane_n;
    logic [31:0]   rdata_q, rdata_n;

    logic          m_en_q, m_en_n;
    logic          m_we_q, m_we_n;
    logic [3:0]    m_be_q, m_be_n;
    logic [31:0]   m_addr_q, m_addr_n;
    logic [31:0]   m_wdata_q, m_wdata_n;

    logic [3:0]    p_be;
    logic [31:0]   p_wd;
    logic          p_mis;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_ext;
    logic          pick_d;
    logic          pick_p;

    always_comb begin
        p_be  = 4'b1111;
        p_wd  = p_wdata;
        p_mis = 1'b0;
        case (p_size)
            2'b00: begin
                p_be = 4'b0001 << p_addr[1:0];
                p_wd = {4{p_wdata[7:0]}};
            end
            2'b01: begin
                p_be  = p_addr[1] ? 4'b1100 : 4'b0011;
                p_wd  = {2{p_wdata[15:0]}};
                p_mis = p_addr[0];
            end
            default: begin
                p_be  = 4'b1111;
                p_wd  = p_wdata;
                p_mis = |p_addr[1:0];
            end
        endcase
    end

    always_comb begin
        ld_byte = m_rdata[{lane_q, 3'b000} +: 8];
        ld_half = lane_q[1] ? m_rdata[31:16] : m_rdata[15:0];
        case (size_q)
            2'b00:   ld_ext = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_ext = m_rdata;
        endcase
    end

    // A waiting secondary request only overrides the pipeline once it has been passed over STARVE_MAX times.
    assign pick_d = d_req && (!p_req || (starve_q >= SW'(STARVE_MAX)));
    assign pick_p = p_req && !pick_d;

    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        starve_n  = d_req ? starve_q : '0;
        own_d_n   = own_d_q;
        we_n      = we_q;
        size_n    = size_q;
        uns_n     = uns_q;
        lane_n    = lane_q;
        rdata_n   = rdata_q;
        m_en_n    = 1'b0;
        m_we_n    = 1'b0;
        m_be_n    = '0;
        m_addr_n  = '0;
        m_wdata_n = '0;
        case (state_q)
            IDLE, DONE: begin
                state_n = IDLE;
                if (pick_d) begin
                    state_n   = ACCESS;
                    cnt_n     = '0;
                    starve_n  = '0;
                    own_d_n   = 1'b1;
                    we_n      = d_we;
                    size_n    = 2'b10;
                    uns_n     = 1'b0;
                    lane_n    = 2'b00;
                    m_en_n    = 1'b1;
                    m_we_n    = d_we;
                    m_be_n    = '1;
                    m_addr_n  = d_addr & ~32'h3;
                    m_wdata_n = d_wdata;
                end else if (pick_p && p_mis) begin
                    state_n = MISAL;
                end else if (pick_p) begin
                    state_n   = ACCESS;
                    cnt_n     = '0;
                    if (d_req && (starve_q < SW'(STARVE_MAX)))
                        starve_n = starve_q + 1'b1;
                    own_d_n   = 1'b0;
                    we_n      = p_we;
                    size_n    = p_size;
                    uns_n     = p_unsigned;
                    lane_n    = p_addr[1:0];
                    m_en_n    = 1'b1;
                    m_we_n    = p_we;
                    m_be_n    = p_be;
                    m_addr_n  = p_addr & ~32'h3;
                    m_wdata_n = p_wd;
                end
            end
            MISAL: state_n = IDLE;
            ACCESS: begin
                if (cnt_q == CW'(LATENCY)) begin
                    state_n = DONE;
                    rdata_n = we_q ? '0 : (own_d_q ? m_rdata : ld_ext);
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            starve_q  <= '0;
            own_d_q   <= 1'b0;
            we_q      <= 1'b0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            lane_q    <= '0;
            rdata_q   <= '0;
            m_en_q    <= 1'b0;
            m_we_q    <= 1'b0;
            m_be_q    <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            starve_q  <= starve_n;
            own_d_q   <= own_d_n;
            we_q      <= we_n;
            size_q    <= size_n;
            uns_q     <= uns_n;
            lane_q    <= lane_n;
            rdata_q   <= rdata_n;
            m_en_q    <= m_en_n;
            m_we_q    <= m_we_n;
            m_be_q    <= m_be_n;
            m_addr_q  <= m_addr_n;
            m_wdata_q <= m_wdata_n;
        end
    end

    assign p_done   = (state_q == MISAL) || ((state_q == DONE) && !own_d_q);
    assign d_done   = (state_q == DONE) && own_d_q;
    assign misalign = (state_q == MISAL);
    assign p_rdata  = ((state_q == DONE) && !own_d_q) ? rdata_q : '0;
    assign d_rdata  = d_done ? rdata_q : '0;
    // Gated by reset so every output reads 0 while reset is held.
    assign p_stall  = reset & p_req & ~p_done;

    assign m_en    = m_en_q;
    assign m_we    = m_we_q;
    assign m_be    = m_be_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: pipeline/secondary accesses, lanes, misalign, starvation, reset.
module tb_dmem_arbiter;

    localparam int unsigned LAT = 2;

    logic        clk;
    logic        reset;
    logic        p_req;
    logic        p_we;
    logic [1:0]  p_size;
    logic        p_unsigned;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    logic [31:0] p_rdata;
    logic        p_done;
    logic        p_stall;
    logic        misalign;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        m_en;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    int checks   = 0;
    int failures = 0;

    int unsigned age;
    logic [31:0] rd_word;

    dmem_arbiter #(.LATENCY(LAT), .STARVE_MAX(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .p_req      (p_req),
        .p_we       (p_we),
        .p_size     (p_size),
        .p_unsigned (p_unsigned),
        .p_addr     (p_addr),
        .p_wdata    (p_wdata),
        .p_rdata    (p_rdata),
        .p_done     (p_done),
        .p_stall    (p_stall),
        .misalign   (misalign),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_done     (d_done),
        .m_en       (m_en),
        .m_we       (m_we),
        .m_be       (m_be),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_rdata    (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory presents the word only in the cycle LAT cycles after m_en; garbage otherwise.
    always @(posedge clk or negedge reset) begin
        if (!reset)                   age <= 0;
        else if (m_en)                age <= 1;
        else if (age > 0 && age < LAT) age <= age + 1;
        else                          age <= 0;
    end
    assign m_rdata = (age == LAT) ? rd_word : 32'hA5A5_A5A5;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic p_access(input string tag, input logic we, input logic [1:0] size,
                            input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rword, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
        p_we = we; p_size = size; p_unsigned = uns; p_addr = addr; p_wdata = wdata;
        rd_word = rword; p_req = 1'b1;
        #1 check({tag, "_stall_req"}, p_stall, 1'b1);
        @(negedge clk);
        check({tag, "_m_en"}, m_en, 1'b1);
        check({tag, "_m_we"}, m_we, we);
        check({tag, "_m_be"}, m_be, exp_be);
        check({tag, "_m_addr"}, m_addr, addr & ~32'h3);
        check({tag, "_m_wdata"}, m_wdata, exp_wdata);
        check({tag, "_stall_acc"}, p_stall, 1'b1);
        @(negedge clk);
        check({tag, "_m_en_once"}, m_en, 1'b0);
        @(negedge clk);
        check({tag, "_early_done"}, p_done, 1'b0);
        @(negedge clk);
        check({tag, "_p_done"}, p_done, 1'b1);
        check({tag, "_p_rdata"}, p_rdata, exp_rdata);
        check({tag, "_stall_done"}, p_stall, 1'b0);
        check({tag, "_d_done"}, d_done, 1'b0);
        p_req = 1'b0;
        @(negedge clk);
        check({tag, "_done_pulse"}, p_done, 1'b0);
    endtask

    task automatic d_access(input string tag, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rword,
                            input logic [31:0] exp_rdata);
        d_we = we; d_addr = addr; d_wdata = wdata; rd_word = rword; d_req = 1'b1;
        @(negedge clk);
        check({tag, "_m_en"}, m_en, 1'b1);
        check({tag, "_m_we"}, m_we, we);
        check({tag, "_m_be"}, m_be, 4'hF);
        check({tag, "_m_addr"}, m_addr, addr & ~32'h3);
        check({tag, "_m_wdata"}, m_wdata, wdata);
        repeat (2) @(negedge clk);
        check({tag, "_early_done"}, d_done, 1'b0);
        @(negedge clk);
        check({tag, "_d_done"}, d_done, 1'b1);
        check({tag, "_d_rdata"}, d_rdata, exp_rdata);
        check({tag, "_p_done"}, p_done, 1'b0);
        d_req = 1'b0;
        @(negedge clk);
        check({tag, "_done_pulse"}, d_done, 1'b0);
    endtask

    task automatic p_misal(input string tag, input logic [1:0] size, input logic [31:0] addr);
        p_we = 1'b0; p_size = size; p_unsigned = 1'b0; p_addr = addr; p_wdata = '0;
        rd_word = 32'h1111_1111; p_req = 1'b1;
        #1 check({tag, "_stall_req"}, p_stall, 1'b1);
        @(negedge clk);
        check({tag, "_misalign"}, misalign, 1'b1);
        check({tag, "_p_done"}, p_done, 1'b1);
        check({tag, "_p_rdata"}, p_rdata, 32'h0);
        check({tag, "_no_m_en"}, m_en, 1'b0);
        check({tag, "_stall_done"}, p_stall, 1'b0);
        p_req = 1'b0;
        @(negedge clk);
        check({tag, "_misalign_pulse"}, misalign, 1'b0);
        check({tag, "_done_pulse"}, p_done, 1'b0);
        check({tag, "_no_m_en2"}, m_en, 1'b0);
    endtask

    initial begin
        logic exp_p;
        logic exp_d;
        reset = 1'b0;
        p_req = 1'b0; p_we = 1'b0; p_size = 2'b00; p_unsigned = 1'b0;
        p_addr = '0; p_wdata = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        rd_word = '0;

        repeat (2) @(negedge clk);
        check("rst_m_en", m_en, 1'b0);
        check("rst_m_be", m_be, 4'h0);
        check("rst_m_addr", m_addr, 32'h0);
        check("rst_p_done", p_done, 1'b0);
        check("rst_d_done", d_done, 1'b0);
        check("rst_misalign", misalign, 1'b0);
        check("rst_p_rdata", p_rdata, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        p_access("word_rd", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 4'hF, 32'h0, 32'hDEAD_BEEF);
        p_access("byte_s", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80AB_1234, 4'h8, 32'h0, 32'hFFFF_FF80);
        p_access("byte_u", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80AB_1234, 4'h8, 32'h0, 32'h0000_0080);
        p_access("byte1_u", 1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 32'h80AB_1234, 4'h2, 32'h0, 32'h0000_0012);
        p_access("byte2_s", 1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 32'h80AB_1234, 4'h4, 32'h0, 32'hFFFF_FFAB);
        p_access("half_hi_s", 1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 32'h80AB_1234, 4'hC, 32'h0, 32'hFFFF_80AB);
        p_access("half_lo_u", 1'b0, 2'b01, 1'b1, 32'h200, 32'h0, 32'h80AB_9234, 4'h3, 32'h0, 32'h0000_9234);
        p_access("half_st", 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_BEEF, 32'h7777_7777, 4'hC, 32'hBEEF_BEEF, 32'h0);
        p_access("byte_st", 1'b1, 2'b00, 1'b0, 32'h101, 32'h1234_565A, 32'h7777_7777, 4'h2, 32'h5A5A_5A5A, 32'h0);
        p_access("word_st", 1'b1, 2'b11, 1'b0, 32'h104, 32'h0102_0304, 32'h7777_7777, 4'hF, 32'h0102_0304, 32'h0);

        p_misal("mis_word", 2'b10, 32'h101);
        p_misal("mis_half", 2'b01, 32'h201);

        d_access("d_rd", 1'b0, 32'h403, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D);
        d_access("d_wr", 1'b1, 32'h503, 32'h1357_9BDF, 32'h7777_7777, 32'h0);

        // Both requesters held: pipeline grants at cycles 1,5,9,13, secondary at 17, pipeline at 21.
        p_we = 1'b0; p_size = 2'b10; p_unsigned = 1'b0; p_addr = 32'h300; p_wdata = '0;
        d_we = 1'b0; d_addr = 32'h403; d_wdata = '0; rd_word = 32'h1234_5678;
        p_req = 1'b1; d_req = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            exp_p = (i % 4 == 0) && (i != 20);
            exp_d = (i == 20);
            check("starve_p_done", p_done, exp_p);
            check("starve_d_done", d_done, exp_d);
            if (i == 13) check("starve_p4_addr", m_addr, 32'h300);
            if (i == 17) begin
                check("starve_d_m_en", m_en, 1'b1);
                check("starve_d_addr", m_addr, 32'h400);
            end
            if (i == 20) check("starve_d_rdata", d_rdata, 32'h1234_5678);
            if (i == 21) check("starve_resume_addr", m_addr, 32'h300);
            if (i == 24) check("starve_p_rdata", p_rdata, 32'h1234_5678);
        end
        p_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        check("starve_end_p_done", p_done, 1'b0);
        check("starve_end_d_done", d_done, 1'b0);

        p_we = 1'b0; p_size = 2'b10; p_unsigned = 1'b0; p_addr = 32'h600; p_wdata = '0;
        rd_word = 32'h2468_ACE0; p_req = 1'b1;
        @(negedge clk);
        check("rstmid_m_en", m_en, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rstmid_stall", p_stall, 1'b0);
        check("rstmid_m_en0", m_en, 1'b0);
        check("rstmid_p_done", p_done, 1'b0);
        p_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rstmid_no_done", p_done, 1'b0);
            check("rstmid_no_m_en", m_en, 1'b0);
        end
        p_access("after_rst", 1'b0, 2'b10, 1'b0, 32'h600, 32'h0, 32'h2468_ACE0, 4'hF, 32'h0, 32'h2468_ACE0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
